// File: rtl/rob_wb_arbiter_if.sv
// Completion-request and busy-clear bundle between the writeback stage and rob_wb_arbiter.
interface rob_wb_arbiter_if #(
  parameter int unsigned WIDTH_BANK = 3,
  parameter int unsigned NREQ       = 6
);
  localparam int unsigned TW = WIDTH_BANK + 2;
  localparam int unsigned BW = TW + 1;

  logic                 i_flush;
  logic [NREQ-1:0]      i_valid;
  logic [NREQ*TW-1:0]   i_tag;
  logic [NREQ-1:0]      o_ready;
  logic [BW-1:0]        o_rst_busy0;
  logic [BW-1:0]        o_rst_busy1;
  logic [BW-1:0]        o_rst_busy2;
  logic [BW-1:0]        o_rst_busy3;
  logic [3:0]           o_pending;

  modport slave (
    input  i_flush, i_valid, i_tag,
    output o_ready, o_rst_busy0, o_rst_busy1, o_rst_busy2, o_rst_busy3, o_pending
  );

  modport master (
    output i_flush, i_valid, i_tag,
    input  o_ready, o_rst_busy0, o_rst_busy1, o_rst_busy2, o_rst_busy3, o_pending
  );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Holds one completion tag per requester and round-robins up to four of them per cycle
// onto the ROB busy-clear ports as registered {EN, bank, set} words.
module rob_wb_arbiter #(
  parameter int unsigned WIDTH_BANK = 3,
  parameter int unsigned NREQ       = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rob_wb_arbiter_if.slave    bus
);
  localparam int unsigned TW    = WIDTH_BANK + 2;
  localparam int unsigned BW    = TW + 1;
  localparam int unsigned PW    = $clog2(NREQ);
  localparam int unsigned NPORT = 4;

  logic [NREQ-1:0]  hold_v_q, hold_v_d;
  logic [TW-1:0]    hold_tag_q [NREQ];
  logic [TW-1:0]    hold_tag_d [NREQ];
  logic [PW-1:0]    rr_q, rr_d;
  logic [BW-1:0]    busy_q [NPORT];
  logic [BW-1:0]    busy_d [NPORT];
  logic [3:0]       pending_q, pending_d;

  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  ready;
  logic [NREQ-1:0]  capture;
  logic [NPORT-1:0] slot_v;
  logic [PW-1:0]    slot_idx [NPORT];
  logic [PW-1:0]    last_idx;
  logic [2:0]       n_grant;
  logic [PW:0]      scan;

  // Round-robin scan from rr_q; the k-th pending holder found drives port k.
  always_comb begin
    grant    = '0;
    slot_v   = '0;
    last_idx = '0;
    n_grant  = '0;
    scan     = '0;
    for (int unsigned k = 0; k < NPORT; k++) slot_idx[k] = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_q} + (PW+1)'(i);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (hold_v_q[scan[PW-1:0]] && (n_grant < 3'd4)) begin
        grant[scan[PW-1:0]]   = 1'b1;
        slot_v[n_grant[1:0]]  = 1'b1;
        slot_idx[n_grant[1:0]] = scan[PW-1:0];
        last_idx              = scan[PW-1:0];
        n_grant               = n_grant + 3'd1;
      end
    end
  end

  // A holder being drained this cycle can accept its replacement in the same cycle.
  always_comb begin
    ready   = {NREQ{~bus.i_flush}} & (~hold_v_q | grant);
    capture = bus.i_valid & ready;
  end

  always_comb begin
    hold_v_d = (hold_v_q & ~grant) | capture;
    for (int unsigned r = 0; r < NREQ; r++) begin
      hold_tag_d[r] = capture[r] ? bus.i_tag[r*TW +: TW] : hold_tag_q[r];
    end
    for (int unsigned k = 0; k < NPORT; k++) begin
      busy_d[k] = slot_v[k] ? {1'b1, hold_tag_q[slot_idx[k]]} : '0;
    end
    rr_d = rr_q;
    if (|grant) begin
      rr_d = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + PW'(1);
    end
    if (bus.i_flush) begin
      hold_v_d = '0;
      rr_d     = '0;
      for (int unsigned k = 0; k < NPORT; k++) busy_d[k] = '0;
    end
    pending_d = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      pending_d = pending_d + 4'(hold_v_d[r]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_v_q  <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      for (int unsigned r = 0; r < NREQ; r++) hold_tag_q[r] <= '0;
      for (int unsigned k = 0; k < NPORT; k++) busy_q[k] <= '0;
    end else begin
      hold_v_q  <= hold_v_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      for (int unsigned r = 0; r < NREQ; r++) hold_tag_q[r] <= hold_tag_d[r];
      for (int unsigned k = 0; k < NPORT; k++) busy_q[k] <= busy_d[k];
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_rst_busy0 = busy_q[0];
  assign bus.o_rst_busy1 = busy_q[1];
  assign bus.o_rst_busy2 = busy_q[2];
  assign bus.o_rst_busy3 = busy_q[3];
  assign bus.o_pending   = pending_q;
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed scenarios plus randomized traffic for rob_wb_arbiter, checked against a
// queue-based reference model of the hold/grant/round-robin rules.
module tb_rob_wb_arbiter;
  localparam int unsigned NREQ = 6;
  localparam int unsigned WB   = 3;
  localparam int unsigned TW   = WB + 2;
  localparam int unsigned BW   = TW + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rob_wb_arbiter_if #(.WIDTH_BANK(WB), .NREQ(NREQ)) bus ();

  rob_wb_arbiter #(.WIDTH_BANK(WB), .NREQ(NREQ)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit              m_hv   [NREQ];
  logic [TW-1:0]   m_tag  [NREQ];
  int              m_age  [NREQ];
  int              m_rr;
  logic [BW-1:0]   m_busy [4];
  logic [NREQ-1:0] m_ready;
  bit              stuck  [NREQ];
  int              g [$];

  logic [NREQ-1:0]    cur_v;
  logic [NREQ*TW-1:0] cur_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pending();
    int n = 0;
    for (int r = 0; r < NREQ; r++) n += int'(m_hv[r]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NREQ; r++) begin
      m_hv[r] = 0; m_tag[r] = '0; m_age[r] = 0; stuck[r] = 0;
    end
    for (int k = 0; k < 4; k++) m_busy[k] = '0;
    m_rr = 0;
  endfunction

  task automatic set_in(input logic [NREQ-1:0] v, input logic [NREQ*TW-1:0] t, input logic f);
    cur_v = v; cur_t = t;
    bus.i_valid = v; bus.i_tag = t; bus.i_flush = f;
  endtask

  task automatic check_outputs();
    check_eq("busy0", 32'(bus.o_rst_busy0), 32'(m_busy[0]));
    check_eq("busy1", 32'(bus.o_rst_busy1), 32'(m_busy[1]));
    check_eq("busy2", 32'(bus.o_rst_busy2), 32'(m_busy[2]));
    check_eq("busy3", 32'(bus.o_rst_busy3), 32'(m_busy[3]));
    check_eq("pending", 32'(bus.o_pending), 32'(model_pending()));
  endtask

  // One clock: check ready against the model, advance the model, check registered outputs.
  task automatic step();
    bit granted;
    g.delete();
    for (int i = 0; i < NREQ; i++) begin
      int idx = (m_rr + i) % NREQ;
      if (m_hv[idx] && g.size() < 4) g.push_back(idx);
    end
    for (int r = 0; r < NREQ; r++) begin
      granted = 0;
      foreach (g[k]) if (g[k] == r) granted = 1;
      m_ready[r] = !bus.i_flush && (!m_hv[r] || granted);
    end
    #1;
    check_eq("ready", 32'(bus.o_ready), 32'(m_ready));
    if (bus.i_flush) begin
      for (int r = 0; r < NREQ; r++) m_hv[r] = 0;
      for (int k = 0; k < 4; k++) m_busy[k] = '0;
      m_rr = 0;
    end else begin
      for (int k = 0; k < 4; k++) m_busy[k] = (k < g.size()) ? {1'b1, m_tag[g[k]]} : '0;
      foreach (g[k]) begin
        check_eq("starve", 32'(m_age[g[k]] <= (NREQ + 3) / 4), 32'd1);
        m_hv[g[k]] = 0;
      end
      for (int r = 0; r < NREQ; r++) if (m_hv[r]) m_age[r]++;
      for (int r = 0; r < NREQ; r++) begin
        if (cur_v[r] && m_ready[r]) begin
          m_hv[r] = 1; m_tag[r] = cur_t[r*TW +: TW]; m_age[r] = 1;
        end
      end
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NREQ;
    end
    for (int r = 0; r < NREQ; r++) stuck[r] = cur_v[r] && !m_ready[r];
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in('0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random traffic; a requester left unaccepted keeps its valid and tag.
  task automatic rand_cycle(input int pct, input bit allow_flush);
    logic [NREQ-1:0]    v = cur_v;
    logic [NREQ*TW-1:0] t = cur_t;
    for (int r = 0; r < NREQ; r++) begin
      if (!stuck[r]) begin
        v[r] = ($urandom_range(99) < pct);
        t[r*TW +: TW] = TW'($urandom);
      end
    end
    set_in(v, t, allow_flush && ($urandom_range(49) == 0));
  endtask

  task automatic scenario_single();
    logic [NREQ*TW-1:0] t = '0;
    t[0 +: TW] = 5'b010_01;
    set_in(6'b000001, t, 1'b0);
    step();
    check_eq("s1_pend1", 32'(bus.o_pending), 32'd1);
    set_in('0, '0, 1'b0);
    step();
    check_eq("s1_busy0", 32'(bus.o_rst_busy0), 32'h29);
    check_eq("s1_busy1", 32'(bus.o_rst_busy1), 32'h0);
    check_eq("s1_pend0", 32'(bus.o_pending), 32'd0);
    step();
    check_eq("s1_busy0_off", 32'(bus.o_rst_busy0), 32'h0);
  endtask

  initial begin
    logic [NREQ*TW-1:0] t;
    bus.i_valid = '0; bus.i_tag = '0; bus.i_flush = 1'b0;
    cur_v = '0; cur_t = '0;
    do_reset();

    // Single completion
    scenario_single();

    // All six at once: 0..3 then 4,5
    do_reset();
    t = '0;
    for (int r = 0; r < NREQ; r++) t[r*TW +: TW] = {3'(r), 2'b00};
    set_in('1, t, 1'b0);
    step();
    check_eq("s2_pend6", 32'(bus.o_pending), 32'd6);
    set_in('0, '0, 1'b0);
    step();
    check_eq("s2_p0", 32'(bus.o_rst_busy0), 32'h20);
    check_eq("s2_p1", 32'(bus.o_rst_busy1), 32'h24);
    check_eq("s2_p2", 32'(bus.o_rst_busy2), 32'h28);
    check_eq("s2_p3", 32'(bus.o_rst_busy3), 32'h2c);
    step();
    check_eq("s2_q0", 32'(bus.o_rst_busy0), 32'h30);
    check_eq("s2_q1", 32'(bus.o_rst_busy1), 32'h34);
    check_eq("s2_q2", 32'(bus.o_rst_busy2), 32'h00);

    // Continuous full load: rotation and starvation bound
    do_reset();
    for (int c = 0; c < 12; c++) rand_cycle(100, 1'b0);
    for (int c = 0; c < 12; c++) begin rand_cycle(100, 1'b0); step(); end

    // Grant and capture on the same requester
    do_reset();
    t = '0; t[2*TW +: TW] = 5'b010_10;
    set_in(6'b000100, t, 1'b0);
    step();
    t[2*TW +: TW] = 5'b101_11;
    set_in(6'b000100, t, 1'b0);
    step();
    check_eq("s4_old", 32'(bus.o_rst_busy0), 32'h2a);
    check_eq("s4_pend", 32'(bus.o_pending), 32'd1);
    set_in('0, '0, 1'b0);
    step();
    check_eq("s4_new", 32'(bus.o_rst_busy0), 32'h37);

    // Flush with four pending
    do_reset();
    set_in(6'b001111, 30'h1234567, 1'b0);
    step();
    set_in(6'b110000, 30'h3ffffff, 1'b1);
    step();
    check_eq("s5_pend", 32'(bus.o_pending), 32'd0);
    set_in('0, '0, 1'b0);
    step();
    check_eq("s5_en", 32'({bus.o_rst_busy0[BW-1], bus.o_rst_busy1[BW-1],
                           bus.o_rst_busy2[BW-1], bus.o_rst_busy3[BW-1]}), 32'd0);

    // Asynchronous reset mid-cycle with three pending and live outputs
    do_reset();
    set_in(6'b000111, 30'h0aaaaaa, 1'b0);
    step();
    set_in(6'b111000, 30'h1555555, 1'b0);
    step();
    set_in('0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("s6_ready", 32'(bus.o_ready), 32'h3f);
    @(negedge clk);
    rst_n = 1'b1;
    scenario_single();

    // Randomized traffic with occasional flushes
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rand_cycle((c / 100) % 2 == 0 ? 40 : 90, 1'b1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
